adc_display_driver: RTL and testbench
=====================================

// Module: adc_display_driver
// PURPOSE
//  Sits downstream of the successive-approximation ADC search stage. It consumes each 8-bit
//  conversion result and converts it to 3-digit BCD with a sequential double-dabble
//  engine. It drives a multiplexed, common-anode 3-digit 7-segment display with optional
//  leading-zero blanking.
// PARAMETERS
//  REFRESH_DIV  1024  clk cycles each digit stays lit before the scan advances (>=2)
//  BLANK_LZ     1     1: blank leading zero digits; 0: always show all three digits
// PORTS
//  clk           in   1   system clock, single clock domain
//  rst           in   1   reset; asynchronous and active-low
//  sample        in   8   conversion result from the ADC search stage
//  sample_valid  in   1   1-cycle strobe, sample is valid in this cycle
//  busy          out  1   high while the BCD engine is converting
//  bcd           out  12  {hundreds,tens,ones} of the last completed conversion
//  seg           out  7   active-low segments {g,f,e,d,c,b,a} for the lit digit
//  an            out  3   active-low digit enables; an[0]=ones, an[1]=tens, an[2]=hundreds
// BEHAVIOUR
//  Reset (rst low, asynchronous): busy=0, bcd=12'h000, seg=7'h7F, an=3'b111.
//    FSM=IDLE; pending cleared; scan index=0; refresh counter=0.
//  FSM: IDLE -> CONV on a latched sample. CONV runs exactly 8 iterations; in each one,
//    add 3 to any BCD nibble >=5, then shift {bcd_work,bin} left by 1.
//    CONV -> DONE after the 8th iteration. DONE -> IDLE, or -> CONV if pending is set.
//  Latency: strobe at cycle N -> busy high from N+1 to N+8 -> bcd updates at the N+9 edge.
//    bcd changes only in DONE and holds between conversions.
//  Width rules: the 20-bit work register is {12-bit BCD, 8-bit bin}.
//    Result range is 000..255, so the hundreds nibble never exceeds 2.
//  Strobe while busy or in DONE: sample goes to a 1-deep pending register; latest wins.
//    The strobe is not dropped silently; it is serviced immediately after DONE.
//    Strobe in IDLE: converted directly and pending stays clear.
//  Scan: refresh counter counts 0..REFRESH_DIV-1. On wrap, scan index steps 0->1->2->0.
//    an/seg are registered and update on the wrap edge.
//    The first digit lights REFRESH_DIV cycles after reset release.
//  Decode: digits 0-9 use the standard pattern, e.g. 0=7'b1000000, 5=7'b0010010,
//    7=7'b1111000. Nibbles >9 are impossible; they decode to blank (7'h7F).
//  Blanking (BLANK_LZ=1): hundreds is blank if 0; tens is blank if hundreds==0 and tens==0.
//    Ones is never blank. A blanked digit drives seg=7'h7F and its an bit 1.
//  Display reads bcd, not the work register, so it never shows partial conversions.
//  rst asserted mid-conversion aborts the conversion; all state returns to reset values.
// STRUCTURE
//  Include file adc_disp_defs.vh holds:
//    FSM state encodings (IDLE, CONV, DONE);
//    the 7-segment pattern constants for 0-9 and blank;
//    the digit-enable constants.
//  One combinational sub-module seg7_decode (4-bit nibble + blank -> 7-bit seg).
//  The BCD FSM and scan counter stay in this module.
// TESTING
//  1 Reset: hold rst low mid-run -> busy=0, bcd=000, seg=7F, an=111 immediately,
//    with no clk edge required.
//  2 sample=255 + strobe -> busy high 8 cycles; bcd=12'h255 at the 9th edge;
//    scan (REFRESH_DIV=4) shows 5,5,2.
//  3 sample=7, BLANK_LZ=1 -> bcd=12'h007; only an[0] ever low, seg=7'b1111000;
//    with BLANK_LZ=0, digits 0,0,7 all light.
//  4 Strobe 100 at N, 200 at N+3, 50 at N+5 -> bcd=100 first, then 050;
//    200 is never shown.
//  5 rst low at the 4th CONV cycle of sample 128, then release, no strobe ->
//    bcd stays 000 and busy stays 0.
//  6 Scan wrap with REFRESH_DIV=4 -> an sequence 111, 110, 101, 011, 110;
//    each step occurs exactly every 4 cycles.

Source files
------------

// File: rtl/adc_display_driver_pkg.sv
`default_nettype none
// ==========================================================================
// adc_display_driver_pkg : FSM states, 7-segment/digit-enable constants, BCD step
// Rev 1.0
// ==========================================================================
package adc_display_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] C_SEG_0     = 7'b1000000;
  localparam logic [6:0] C_SEG_1     = 7'b1111001;
  localparam logic [6:0] C_SEG_2     = 7'b0100100;
  localparam logic [6:0] C_SEG_3     = 7'b0110000;
  localparam logic [6:0] C_SEG_4     = 7'b0011001;
  localparam logic [6:0] C_SEG_5     = 7'b0010010;
  localparam logic [6:0] C_SEG_6     = 7'b0000010;
  localparam logic [6:0] C_SEG_7     = 7'b1111000;
  localparam logic [6:0] C_SEG_8     = 7'b0000000;
  localparam logic [6:0] C_SEG_9     = 7'b0010000;
  localparam logic [6:0] C_SEG_BLANK = 7'b1111111;

  localparam logic [2:0] C_AN_OFF   = 3'b111;
  localparam logic [2:0] C_AN_ONES  = 3'b110;
  localparam logic [2:0] C_AN_TENS  = 3'b101;
  localparam logic [2:0] C_AN_HUNDS = 3'b011;

  localparam int C_ITERATIONS = 8;

  // One double-dabble iteration on {bcd[11:0], bin[7:0]}
  function automatic logic [19:0] dd_step(input logic [19:0] i_work);
    logic [19:0] w_t;
    w_t = i_work;
    for (int d = 0; d < 3; d++) begin
      if (w_t[8+4*d +: 4] >= 4'd5) begin
        w_t[8+4*d +: 4] = w_t[8+4*d +: 4] + 4'd3;
      end
    end
    return {w_t[18:0], 1'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_display_driver_seg7_decode.sv
`default_nettype none
// ==========================================================================
// seg7_decode : BCD nibble to active-low 7-segment pattern with blanking
// Rev 1.0
// ==========================================================================
module seg7_decode
  import adc_display_driver_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = C_SEG_BLANK;
    if (!i_blank) begin
      case (i_nibble)
        4'd0:    o_seg = C_SEG_0;
        4'd1:    o_seg = C_SEG_1;
        4'd2:    o_seg = C_SEG_2;
        4'd3:    o_seg = C_SEG_3;
        4'd4:    o_seg = C_SEG_4;
        4'd5:    o_seg = C_SEG_5;
        4'd6:    o_seg = C_SEG_6;
        4'd7:    o_seg = C_SEG_7;
        4'd8:    o_seg = C_SEG_8;
        4'd9:    o_seg = C_SEG_9;
        default: o_seg = C_SEG_BLANK;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/adc_display_driver.sv
`default_nettype none
// ==========================================================================
// adc_display_driver : 8-bit sample -> BCD (double-dabble) -> muxed 3-digit display
// Rev 1.0
// ==========================================================================
module adc_display_driver
  import adc_display_driver_pkg::*;
#(
  parameter int REFRESH_DIV = 1024,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  sample,
  input  logic        sample_valid,
  output logic        busy,
  output logic [11:0] bcd,
  output logic [6:0]  seg,
  output logic [2:0]  an
);

  localparam int                 C_CNT_W   = $clog2(REFRESH_DIV);
  localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(REFRESH_DIV - 1);

  state_t       r_state;
  logic [19:0]  r_work;
  logic [2:0]   r_iter;
  logic [7:0]   r_pend;
  logic         r_pend_valid;
  logic         r_busy;
  logic [11:0]  r_bcd;

  logic [C_CNT_W-1:0] r_refresh;
  logic [1:0]         r_idx;
  logic [6:0]         r_seg;
  logic [2:0]         r_an;

  logic [19:0] w_step;
  logic [3:0]  w_nib;
  logic        w_blank;
  logic [2:0]  w_an_sel;
  logic [6:0]  w_seg;

  assign w_step = dd_step(r_work);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_work       <= 20'h00000;
      r_iter       <= 3'd0;
      r_pend       <= 8'h00;
      r_pend_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_bcd        <= 12'h000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (sample_valid) begin
            r_work  <= {12'h000, sample};
            r_iter  <= 3'd0;
            r_busy  <= 1'b1;
            r_state <= ST_CONV;
          end
        end
        ST_CONV: begin
          r_work <= w_step;
          r_iter <= r_iter + 3'd1;
          if (sample_valid) begin
            r_pend       <= sample;
            r_pend_valid <= 1'b1;
          end
          if (r_iter == 3'(C_ITERATIONS - 1)) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_bcd   <= w_step[19:8];
          end
        end
        ST_DONE: begin
          // A strobe landing in this very cycle is newer than anything pending
          if (sample_valid || r_pend_valid) begin
            r_work       <= {12'h000, (sample_valid ? sample : r_pend)};
            r_iter       <= 3'd0;
            r_busy       <= 1'b1;
            r_pend_valid <= 1'b0;
            r_state      <= ST_CONV;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_nib    = r_bcd[3:0];
    w_an_sel = C_AN_ONES;
    w_blank  = 1'b0;
    case (r_idx)
      2'd1: begin
        w_nib    = r_bcd[7:4];
        w_an_sel = C_AN_TENS;
        w_blank  = BLANK_LZ && (r_bcd[11:8] == 4'd0) && (r_bcd[7:4] == 4'd0);
      end
      2'd2: begin
        w_nib    = r_bcd[11:8];
        w_an_sel = C_AN_HUNDS;
        w_blank  = BLANK_LZ && (r_bcd[11:8] == 4'd0);
      end
      default: ;
    endcase
  end

  seg7_decode u_seg7_decode (
    .i_nibble (w_nib),
    .i_blank  (w_blank),
    .o_seg    (w_seg)
  );

  // The digit selected by r_idx is latched on the wrap edge, then the index advances
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_refresh <= '0;
      r_idx     <= 2'd0;
      r_seg     <= C_SEG_BLANK;
      r_an      <= C_AN_OFF;
    end else if (r_refresh == C_CNT_MAX) begin
      r_refresh <= '0;
      r_idx     <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
      r_seg     <= w_seg;
      r_an      <= w_blank ? C_AN_OFF : w_an_sel;
    end else begin
      r_refresh <= r_refresh + 1'b1;
    end
  end

  assign busy = r_busy;
  assign bcd  = r_bcd;
  assign seg  = r_seg;
  assign an   = r_an;

endmodule
`default_nettype wire

// File: tb/tb_adc_display_driver.sv
`default_nettype none
// ==========================================================================
// tb_adc_display_driver : randomized self-checking bench against an arithmetic model
// Rev 1.0
// ==========================================================================
module tb_adc_display_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  sample = 8'h00;
  logic        sample_valid = 1'b0;

  logic        busy,    busy_nb;
  logic [11:0] bcd,     bcd_nb;
  logic [6:0]  seg,     seg_nb;
  logic [2:0]  an,      an_nb;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;
  int model_val;
  bit have_last;
  logic [9:0] last_e1, last_e0;
  int s_off[$];
  int s_val[$];

  logic [6:0] SEG_TAB [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  adc_display_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .sample(sample), .sample_valid(sample_valid),
    .busy(busy), .bcd(bcd), .seg(seg), .an(an)
  );

  adc_display_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .sample(sample), .sample_valid(sample_valid),
    .busy(busy_nb), .bcd(bcd_nb), .seg(seg_nb), .an(an_nb)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return 12'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
  endfunction

  // {an, seg} expected while digit idx is lit, given the displayed decimal value
  function automatic logic [9:0] disp_model(input int v, input int idx, input bit blz);
    int p;
    logic [2:0] a;
    p = (idx == 0) ? 1 : (idx == 1) ? 10 : 100;
    if (blz && idx > 0 && v < p) return {3'b111, 7'h7F};
    a = 3'b111;
    a[idx] = 1'b0;
    return {a, SEG_TAB[(v / p) % 10]};
  endfunction

  task automatic scan_window(input int n);
    int idx;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (cyc > 0 && cyc % 4 == 0) begin
        idx     = (cyc / 4 - 1) % 3;
        last_e1 = disp_model(model_val, idx, 1'b1);
        last_e0 = disp_model(model_val, idx, 1'b0);
        have_last = 1'b1;
        check("scan_an",     an,     last_e1[9:7]);
        check("scan_seg",    seg,    last_e1[6:0]);
        check("scan_an_nb",  an_nb,  last_e0[9:7]);
        check("scan_seg_nb", seg_nb, last_e0[6:0]);
      end else if (have_last) begin
        check("hold_an",    an,    last_e1[9:7]);
        check("hold_an_nb", an_nb, last_e0[9:7]);
      end
    end
  endtask

  // Drive the strobes queued in s_off/s_val (ascending offsets) and collect completed results
  task automatic run_sched(input int exp_busy_len);
    int got[$];
    int exp_q[$];
    int busy_cnt;
    bit prev_busy;
    have_last = 1'b0;
    exp_q.push_back(s_val[0]);
    if (s_val.size() > 1) exp_q.push_back(s_val[s_val.size()-1]);
    busy_cnt  = 0;
    prev_busy = 1'b0;
    for (int k = 0; k < 40; k++) begin
      sample_valid = 1'b0;
      foreach (s_off[i]) begin
        if (s_off[i] == k) begin
          sample       = 8'(s_val[i]);
          sample_valid = 1'b1;
        end
      end
      @(posedge clk); #1;
      sample_valid = 1'b0;
      if (busy) busy_cnt++;
      if (prev_busy && !busy) got.push_back(int'(bcd));
      prev_busy = busy;
    end
    check("n_results", got.size(), exp_q.size());
    foreach (exp_q[i]) begin
      check("bcd_seq", (i < got.size()) ? got[i] : 32'hFFFF_FFFF, to_bcd(exp_q[i]));
    end
    if (exp_busy_len > 0) check("busy_len", busy_cnt, exp_busy_len);
    check("busy_idle", busy, 0);
    check("bcd_final", bcd, to_bcd(exp_q[exp_q.size()-1]));
    check("bcd_nb", bcd_nb, to_bcd(exp_q[exp_q.size()-1]));
    model_val = exp_q[exp_q.size()-1];
    s_off.delete();
    s_val.delete();
  endtask

  task automatic single(input int v);
    s_off.push_back(0);
    s_val.push_back(v);
    run_sched(8);
  endtask

  initial begin
    int off1, off2, nextra, busy_seen;
    model_val = 0;
    have_last = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_bcd",  bcd,  12'h000);
    check("rst_seg",  seg,  7'h7F);
    check("rst_an",   an,   3'b111);

    @(negedge clk);
    rst = 1'b1;
    last_e1 = {3'b111, 7'h7F};
    last_e0 = {3'b111, 7'h7F};
    have_last = 1'b1;
    scan_window(14);

    single(255);
    scan_window(14);
    single(7);
    scan_window(14);

    s_off.push_back(0); s_val.push_back(100);
    s_off.push_back(3); s_val.push_back(200);
    s_off.push_back(5); s_val.push_back(50);
    run_sched(0);
    scan_window(14);

    for (int r = 0; r < 16; r++) begin
      s_off.push_back(0);
      s_val.push_back(int'($urandom_range(0, 255)));
      nextra = int'($urandom_range(0, 2));
      off1 = int'($urandom_range(1, 5));
      off2 = int'($urandom_range(off1 + 1, 9));
      if (nextra >= 1) begin s_off.push_back(off1); s_val.push_back(int'($urandom_range(0, 255))); end
      if (nextra == 2) begin s_off.push_back(off2); s_val.push_back(int'($urandom_range(0, 255))); end
      run_sched((nextra == 0) ? 8 : 0);
      scan_window(8);
    end

    single(93);
    scan_window(12);

    // Asynchronous reset in the 4th conversion cycle of 128
    sample = 8'd128;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_bcd",  bcd,  12'h000);
    check("arst_seg",  seg,  7'h7F);
    check("arst_an",   an,   3'b111);
    check("arst_an_nb", an_nb, 3'b111);
    @(negedge clk);
    rst = 1'b1;
    model_val = 0;
    have_last = 1'b0;
    busy_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (busy) busy_seen++;
    end
    check("post_rst_busy", busy_seen, 0);
    check("post_rst_bcd", bcd, 12'h000);
    scan_window(14);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
